toy_fetch_pcgen: RTL

Fetch PC generator and instruction buffer sitting directly downstream of the commit stage and upstream of decode. It owns the architectural fetch PC and issues in-order word fetch requests to instruction memory. It buffers returned instructions in a small FIFO for decode. It stalls after control-flow instructions until commit releases it, honours commit's PC lock, and discards wrong-path data on redirect.

---
 rtl/toy_fetch_pcgen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/toy_fetch_pcgen.sv
// Fetch PC generator with credit-limited word fetch and an in-order instruction buffer.
// Stalls after control flow until commit releases it; a redirect flushes and drops wrong-path responses.
module toy_fetch_pcgen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RST_PC     = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_release_en,
  input  logic                  pc_update_en,
  input  logic [ADDR_WIDTH-1:0] pc_val,
  input  logic                  pc_lock,
  input  logic                  stall_set,
  output logic                  fetch_req_vld,
  input  logic                  fetch_req_rdy,
  output logic [ADDR_WIDTH-1:0] fetch_req_addr,
  input  logic                  fetch_rsp_vld,
  input  logic [INST_WIDTH-1:0] fetch_rsp_data,
  output logic                  inst_vld,
  input  logic                  inst_rdy,
  output logic [INST_WIDTH-1:0] inst_pld,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, STALL} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0]        inflight_reg, inflight_next;
  logic [CNT_W-1:0]        drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]        pcq_wr_reg, pcq_wr_next;
  logic [PTR_W-1:0]        pcq_rd_reg, pcq_rd_next;

  logic [ADDR_WIDTH-1:0]   pcq_mem       [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc_mem   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0]   fifo_data_mem [FIFO_DEPTH];

  logic redirect, credit_ok, req_fire, rsp_drop, rsp_push, inst_pop;

  assign redirect  = pc_release_en && pc_update_en;
  // Every outstanding request owns a future FIFO slot, so the buffer cannot overflow.
  assign credit_ok = ({1'b0, inflight_reg} + {1'b0, count_reg}) < DEPTH_LIM;

  assign fetch_req_vld  = rst_n && (state_reg == RUN) && !pc_lock && !redirect && credit_ok;
  assign fetch_req_addr = fetch_pc_reg;
  assign req_fire       = fetch_req_vld && fetch_req_rdy;

  assign rsp_drop = fetch_rsp_vld && (drop_cnt_reg != '0);
  assign rsp_push = fetch_rsp_vld && !rsp_drop && !redirect;

  assign inst_vld = rst_n && (state_reg == RUN) && !pc_lock && (count_reg != '0);
  assign inst_pop = inst_vld && inst_rdy && !redirect;
  assign inst_pld = (count_reg != '0) ? fifo_data_mem[rd_ptr_reg] : '0;
  assign inst_pc  = (count_reg != '0) ? fifo_pc_mem[rd_ptr_reg]   : '0;

  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (stall_set)     state_next = STALL;
        STALL:   if (pc_release_en) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect)      fetch_pc_next = pc_val & ~ADDR_WIDTH'(3);
    else if (req_fire) fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);

    inflight_next = inflight_reg + CNT_W'(req_fire) - CNT_W'(fetch_rsp_vld);
    // Anything still in flight after a redirect is wrong-path and must be discarded.
    drop_cnt_next = redirect ? inflight_next : drop_cnt_reg - CNT_W'(rsp_drop);

    // PC queue pops on every response, dropped or not, so it stays aligned with memory order.
    pcq_wr_next = pcq_wr_reg + PTR_W'(req_fire);
    pcq_rd_next = pcq_rd_reg + PTR_W'(fetch_rsp_vld);

    wr_ptr_next = wr_ptr_reg + PTR_W'(rsp_push);
    rd_ptr_next = rd_ptr_reg + PTR_W'(inst_pop);
    count_next  = count_reg + CNT_W'(rsp_push) - CNT_W'(inst_pop);
    if (redirect) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      fetch_pc_reg <= RST_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pcq_wr_reg   <= '0;
      pcq_rd_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      pcq_wr_reg   <= pcq_wr_next;
      pcq_rd_reg   <= pcq_rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
    if (rsp_push) begin
      fifo_pc_mem[wr_ptr_reg]   <= pcq_mem[pcq_rd_reg];
      fifo_data_mem[wr_ptr_reg] <= fetch_rsp_data;
    end
  end

endmodule
